atomic_unit: RTL and testbench

ATOMIC_UNIT -- requirements
Module: atomic_unit

---
 rtl/atomic_unit_pkg.sv | 35 +++
 rtl/atomic_unit_amo_alu.sv | 47 ++++
 rtl/atomic_unit.sv | 160 ++++++++++++++++
 tb/tb_atomic_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/atomic_unit_pkg.sv
// Shared AMO configuration: funct5/funct3 encodings, FSM state encoding and opcode decode helper.
package atomic_unit_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        WRITE  = 3'd2,
        SC_CHK = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [4:0] F5_ADD  = 5'b00000;
    localparam logic [4:0] F5_SWAP = 5'b00001;
    localparam logic [4:0] F5_LR   = 5'b00010;
    localparam logic [4:0] F5_SC   = 5'b00011;
    localparam logic [4:0] F5_XOR  = 5'b00100;
    localparam logic [4:0] F5_OR   = 5'b01000;
    localparam logic [4:0] F5_AND  = 5'b01100;
    localparam logic [4:0] F5_MIN  = 5'b10000;
    localparam logic [4:0] F5_MAX  = 5'b10100;
    localparam logic [4:0] F5_MINU = 5'b11000;
    localparam logic [4:0] F5_MAXU = 5'b11100;

    localparam logic [2:0] F3_W = 3'b010;
    localparam logic [2:0] F3_D = 3'b011;

    function automatic logic f5_known(input logic [4:0] f);
        case (f)
            F5_ADD, F5_SWAP, F5_LR, F5_SC, F5_XOR, F5_OR, F5_AND,
            F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/atomic_unit_amo_alu.sv
// Combinational AMO operator: computes the value written back from old memory value and rs2.
module amo_alu
    import atomic_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      funct5,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    input  logic            word,
    output logic [XLEN-1:0] new_val
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic signed [XLEN-1:0] a;
    logic signed [XLEN-1:0] b;
    logic [XLEN-1:0]        r;
    logic                   lt_s;
    logic                   lt_u;

    // Word operands are sign-extended first; this keeps both signed and unsigned ordering intact.
    always_comb begin
        a    = word ? sext32(old_val[31:0]) : old_val;
        b    = word ? sext32(src[31:0])     : src;
        lt_s = a < b;
        lt_u = $unsigned(a) < $unsigned(b);
        case (funct5)
            F5_ADD:  r = a + b;
            F5_XOR:  r = a ^ b;
            F5_AND:  r = a & b;
            F5_OR:   r = a | b;
            F5_MIN:  r = lt_s ? a : b;
            F5_MAX:  r = lt_s ? b : a;
            F5_MINU: r = lt_u ? a : b;
            F5_MAXU: r = lt_u ? b : a;
            default: r = b;
        endcase
        new_val = word ? sext32(r[31:0]) : r;
    end

endmodule

// File: rtl/atomic_unit.sv
// RISC-V A-extension execution unit: LR/SC and read-modify-write AMOs over a simple ready/req bus.
module atomic_unit
    import atomic_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [4:0]      funct5,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] src,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            misaligned,
    output logic            illegal,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [2:0]      mem_size,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            lr_valid,
    output logic [XLEN-1:0] lr_addr,
    output logic            sc_valid,
    output logic [XLEN-1:0] sc_addr,
    input  logic            sc_success
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [4:0]      f5_q;
    logic            word_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] src_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] result_q;
    logic            mis_q;
    logic            ill_q;

    logic            start_ill;
    logic            start_mis;
    logic [XLEN-1:0] loaded;
    logic [XLEN-1:0] alu_out;

    assign start_ill = !f5_known(funct5) ||
                       !((funct3 == F3_W) || ((funct3 == F3_D) && (XLEN == 64)));
    assign start_mis = (funct3 == F3_D) ? (addr[2:0] != 3'd0) : (addr[1:0] != 2'd0);
    assign loaded    = word_q ? sext32(mem_rdata[31:0]) : mem_rdata;

    amo_alu #(.XLEN(XLEN)) u_alu (
        .funct5  (f5_q),
        .old_val (loaded),
        .src     (src_q),
        .word    (word_q),
        .new_val (alu_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        done     = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        lr_valid = 1'b0;
        sc_valid = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (start_ill || start_mis) state_d = DONE;
                    else if (funct5 == F5_SC)   state_d = SC_CHK;
                    else                        state_d = READ;
                end
            end
            READ: begin
                mem_req  = 1'b1;
                lr_valid = mem_ready && (f5_q == F5_LR);
                if (mem_ready) state_d = (f5_q == F5_LR) ? DONE : WRITE;
            end
            WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ready) state_d = DONE;
            end
            SC_CHK: begin
                sc_valid = 1'b1;
                state_d  = sc_success ? WRITE : DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields only change on accepted start or state transitions, so the bus sees them stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f5_q     <= '0;
            word_q   <= 1'b1;
            addr_q   <= '0;
            src_q    <= '0;
            wdata_q  <= '0;
            result_q <= '0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    f5_q     <= funct5;
                    word_q   <= (funct3 != F3_D);
                    addr_q   <= addr;
                    src_q    <= src;
                    result_q <= '0;
                    mis_q    <= !start_ill && start_mis;
                    ill_q    <= start_ill;
                end
                READ: if (mem_ready) begin
                    result_q <= loaded;
                    wdata_q  <= alu_out;
                end
                SC_CHK: begin
                    if (sc_success) begin
                        wdata_q  <= word_q ? sext32(src_q[31:0]) : src_q;
                        result_q <= '0;
                    end else begin
                        result_q <= {{(XLEN-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign result     = result_q;
    assign misaligned = mis_q;
    assign illegal    = ill_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_size   = word_q ? F3_W : F3_D;
    assign lr_addr    = addr_q;
    assign sc_addr    = addr_q;

endmodule

// File: tb/tb_atomic_unit.sv
// Directed bench for atomic_unit: table of single operations plus reset-abort and busy-start sequences.
module tb_atomic_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic [4:0]      funct5;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] src;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            misaligned;
    logic            illegal;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [2:0]      mem_size;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;
    logic            lr_valid;
    logic [XLEN-1:0] lr_addr;
    logic            sc_valid;
    logic [XLEN-1:0] sc_addr;
    logic            sc_success;

    atomic_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .funct5     (funct5),
        .funct3     (funct3),
        .addr       (addr),
        .src        (src),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .misaligned (misaligned),
        .illegal    (illegal),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_size   (mem_size),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .lr_valid   (lr_valid),
        .lr_addr    (lr_addr),
        .sc_valid   (sc_valid),
        .sc_addr    (sc_addr),
        .sc_success (sc_success)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  f5;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] src;
        logic [31:0] mem;
        logic        sc_ok;
        int          lat;
        logic        poke;
        logic [31:0] exp_res;
        logic        exp_mis;
        logic        exp_ill;
        int          exp_wr;
        logic [31:0] exp_wdata;
        int          exp_lr;
        int          exp_sc;
        logic        exp_req;
    } vec_t;

    vec_t vecs[16];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int          wcnt = 0;
        int          wr = 0;
        int          lr = 0;
        int          sc = 0;
        logic        reqs = 1'b0;
        logic        bus_ok = 1'b1;
        logic        got = 1'b0;
        logic [31:0] res = '0;
        logic [31:0] wdata = '0;
        logic        mis = 1'b0;
        logic        ill = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        funct5 = v.f5;
        funct3 = v.f3;
        addr   = v.addr;
        src    = v.src;
        @(negedge clk);
        start  = 1'b0;
        funct5 = 5'b00011;
        funct3 = 3'b010;
        addr   = 32'hDEAD_BEE0;
        src    = 32'h5555_5555;
        for (int cyc = 0; cyc < 60 && !got; cyc++) begin
            start      = v.poke && (cyc == 1);
            mem_ready  = mem_req && (wcnt >= v.lat);
            mem_rdata  = v.mem;
            sc_success = v.sc_ok;
            #1;
            if (mem_req) begin
                reqs = 1'b1;
                if (mem_addr !== v.addr || mem_size !== 3'b010) bus_ok = 1'b0;
            end
            if (mem_we && mem_ready) begin
                wr++;
                wdata = mem_wdata;
            end
            if (lr_valid) begin
                lr++;
                if (lr_addr !== v.addr) bus_ok = 1'b0;
            end
            if (sc_valid) begin
                sc++;
                if (sc_addr !== v.addr) bus_ok = 1'b0;
            end
            if (lr_valid && sc_valid) bus_ok = 1'b0;
            if (mem_req && !mem_ready) wcnt++;
            else wcnt = 0;
            if (done) begin
                got = 1'b1;
                res = result;
                mis = misaligned;
                ill = illegal;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk({tag, " done"}, 64'(got), 64'd1);
        chk({tag, " result"}, 64'(res), 64'(v.exp_res));
        chk({tag, " misaligned"}, 64'(mis), 64'(v.exp_mis));
        chk({tag, " illegal"}, 64'(ill), 64'(v.exp_ill));
        chk({tag, " writes"}, 64'(wr), 64'(v.exp_wr));
        if (v.exp_wr > 0) chk({tag, " wdata"}, 64'(wdata), 64'(v.exp_wdata));
        chk({tag, " lr pulses"}, 64'(lr), 64'(v.exp_lr));
        chk({tag, " sc pulses"}, 64'(sc), 64'(v.exp_sc));
        chk({tag, " mem_req seen"}, 64'(reqs), 64'(v.exp_req));
        chk({tag, " bus fields"}, 64'(bus_ok), 64'd1);
        chk({tag, " hold"}, {30'd0, busy, done, result}, {32'd0, v.exp_res});
        chk({tag, " flags hold"}, {62'd0, misaligned, illegal}, {62'd0, v.exp_mis, v.exp_ill});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctrl zero"},
            {56'd0, busy, done, mem_req, mem_we, lr_valid, sc_valid, misaligned, illegal}, 64'd0);
        chk({tag, " data zero"},
            64'(result | mem_addr | mem_wdata | lr_addr | sc_addr), 64'd0);
    endtask

    initial begin
        vecs[0]  = '{5'b00000, 3'b010, 32'h100, 32'h1, 32'h7FFFFFFF, 1'b0, 0, 1'b0,
                     32'h7FFFFFFF, 1'b0, 1'b0, 1, 32'h80000000, 0, 0, 1'b1};
        vecs[1]  = '{5'b00010, 3'b010, 32'h200, 32'h0, 32'h12345678, 1'b0, 1, 1'b0,
                     32'h12345678, 1'b0, 1'b0, 0, 32'h0, 1, 0, 1'b1};
        vecs[2]  = '{5'b00011, 3'b010, 32'h200, 32'hAA, 32'h0, 1'b1, 0, 1'b0,
                     32'h0, 1'b0, 1'b0, 1, 32'hAA, 0, 1, 1'b1};
        vecs[3]  = '{5'b00011, 3'b010, 32'h204, 32'hAA, 32'h0, 1'b0, 0, 1'b0,
                     32'h1, 1'b0, 1'b0, 0, 32'h0, 0, 1, 1'b0};
        vecs[4]  = '{5'b10000, 3'b010, 32'h100, 32'h1, 32'hFFFFFFFF, 1'b0, 1, 1'b0,
                     32'hFFFFFFFF, 1'b0, 1'b0, 1, 32'hFFFFFFFF, 0, 0, 1'b1};
        vecs[5]  = '{5'b11000, 3'b010, 32'h100, 32'h1, 32'hFFFFFFFF, 1'b0, 0, 1'b0,
                     32'hFFFFFFFF, 1'b0, 1'b0, 1, 32'h1, 0, 0, 1'b1};
        vecs[6]  = '{5'b10100, 3'b010, 32'h108, 32'h5, 32'h80000000, 1'b0, 0, 1'b0,
                     32'h80000000, 1'b0, 1'b0, 1, 32'h5, 0, 0, 1'b1};
        vecs[7]  = '{5'b11100, 3'b010, 32'h108, 32'h5, 32'h80000000, 1'b0, 2, 1'b0,
                     32'h80000000, 1'b0, 1'b0, 1, 32'h80000000, 0, 0, 1'b1};
        vecs[8]  = '{5'b00100, 3'b010, 32'h10C, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 0, 1'b0,
                     32'hF0F0F0F0, 1'b0, 1'b0, 1, 32'h0FF00FF0, 0, 0, 1'b1};
        vecs[9]  = '{5'b01100, 3'b010, 32'h10C, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 0, 1'b0,
                     32'hF0F0F0F0, 1'b0, 1'b0, 1, 32'hF000F000, 0, 0, 1'b1};
        vecs[10] = '{5'b01000, 3'b010, 32'h10C, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 0, 1'b0,
                     32'hF0F0F0F0, 1'b0, 1'b0, 1, 32'hFFF0FFF0, 0, 0, 1'b1};
        vecs[11] = '{5'b00001, 3'b010, 32'h300, 32'h2, 32'h1, 1'b0, 3, 1'b1,
                     32'h1, 1'b0, 1'b0, 1, 32'h2, 0, 0, 1'b1};
        vecs[12] = '{5'b00001, 3'b010, 32'h102, 32'h2, 32'h1, 1'b0, 0, 1'b0,
                     32'h0, 1'b1, 1'b0, 0, 32'h0, 0, 0, 1'b0};
        vecs[13] = '{5'b11111, 3'b010, 32'h100, 32'h2, 32'h1, 1'b0, 0, 1'b0,
                     32'h0, 1'b0, 1'b1, 0, 32'h0, 0, 0, 1'b0};
        vecs[14] = '{5'b00000, 3'b011, 32'h100, 32'h2, 32'h1, 1'b0, 0, 1'b0,
                     32'h0, 1'b0, 1'b1, 0, 32'h0, 0, 0, 1'b0};
        vecs[15] = '{5'b00000, 3'b000, 32'h100, 32'h2, 32'h1, 1'b0, 0, 1'b0,
                     32'h0, 1'b0, 1'b1, 0, 32'h0, 0, 0, 1'b0};

        reset_n    = 1'b0;
        start      = 1'b0;
        funct5     = '0;
        funct3     = 3'b010;
        addr       = '0;
        src        = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        sc_success = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Reset while a write waits for mem_ready.
        @(negedge clk);
        start  = 1'b1;
        funct5 = 5'b00000;
        funct3 = 3'b010;
        addr   = 32'h100;
        src    = 32'h1;
        @(negedge clk);
        start     = 1'b0;
        mem_rdata = 32'h7FFFFFFF;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort write pending", {62'd0, mem_req, mem_we}, 64'd3);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        reset_n = 1'b1;
        run_op(vecs[0], "after abort");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
